// File: rtl/dcache_store_coalescer.sv
`default_nettype none
// ==========================================================================
// dcache_store_coalescer: posted doubleword store FIFO draining to the dcache
// over req/gnt/tag_valid. Optional merging: STORE_COALESCE_EN.  Rev 1.0
// ==========================================================================
module dcache_store_coalescer #(
  parameter int DEPTH   = 4,
  parameter int PLEN    = 56,
  parameter int INDEX_W = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    st_valid_i,
  output logic                    st_ready_o,
  input  logic [PLEN-1:0]         st_addr_i,
  input  logic [63:0]             st_data_i,
  input  logic [7:0]              st_be_i,
  input  logic                    flush_i,
  output logic                    flush_ack_o,
  output logic                    empty_o,
  input  logic [PLEN-1:0]         ld_addr_i,
  output logic                    ld_match_o,
  output logic                    req_o,
  input  logic                    gnt_i,
  output logic [INDEX_W-1:0]      index_o,
  output logic [PLEN-INDEX_W-1:0] tag_o,
  output logic                    tag_valid_o,
  output logic                    we_o,
  output logic [7:0]              be_o,
  output logic [63:0]             wdata_o,
  output logic [1:0]              size_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = PLEN - 3;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_TAG = 2'd2} state_e;

  state_e         state_q;
  logic [AW-1:0]  addr_q [DEPTH];
  logic [63:0]    data_q [DEPTH];
  logic [7:0]     be_q   [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q, young_ptr, offs;
  logic [CW-1:0]  count_q, count_d;
  logic           ack_seen_q;
  logic [AW-1:0]  st_dw;
  logic           merge_hit, accept, alloc, free, head_locked;
  logic           unused_ok;

  assign unused_ok   = ^{st_addr_i[2:0], ld_addr_i[2:0]};
  assign st_dw       = st_addr_i[PLEN-1:3];
  assign young_ptr   = wr_ptr_q - 1'b1;
  assign head_locked = (state_q != S_IDLE);

`ifdef STORE_COALESCE_EN
  // Youngest entry is the locked head only when it is the sole entry.
  assign merge_hit = (count_q != '0) && !(head_locked && (count_q == CW'(1)))
                     && (addr_q[young_ptr] == st_dw);
`else
  assign merge_hit = 1'b0;
`endif

  assign st_ready_o = !flush_i && ((count_q < CW'(DEPTH)) || merge_hit);
  assign accept     = st_valid_i && st_ready_o;
  assign alloc      = accept && !merge_hit;
  assign free       = (state_q == S_TAG);
  assign count_d    = count_q + CW'(alloc) - CW'(free);

  assign empty_o     = (count_q == '0) && (state_q == S_IDLE);
  assign flush_ack_o = flush_i && empty_o && !ack_seen_q;
  assign req_o       = (state_q == S_REQ);
  assign tag_valid_o = (state_q == S_TAG);
  assign we_o        = 1'b1;
  assign size_o      = 2'b11;
  assign index_o     = {addr_q[rd_ptr_q][INDEX_W-4:0], 3'b000};
  assign tag_o       = addr_q[rd_ptr_q][AW-1:INDEX_W-3];
  assign be_o        = be_q[rd_ptr_q];
  assign wdata_o     = data_q[rd_ptr_q];

  always_comb begin
    ld_match_o = 1'b0;
    offs       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - rd_ptr_q;
      if ((CW'(offs) < count_q) && (addr_q[i] == ld_addr_i[PLEN-1:3]))
        ld_match_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ack_seen_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (alloc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (free)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case (state_q)
        S_IDLE:  if (count_q != '0) state_q <= S_REQ;
        S_REQ:   if (gnt_i) state_q <= S_TAG;
        S_TAG:   state_q <= (count_d != '0) ? S_REQ : S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      // One ack per flush request; re-armed once flush_i drops.
      if (flush_ack_o)   ack_seen_q <= 1'b1;
      else if (!flush_i) ack_seen_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (alloc) begin
      addr_q[wr_ptr_q] <= st_dw;
      data_q[wr_ptr_q] <= st_data_i;
      be_q[wr_ptr_q]   <= st_be_i;
    end else if (accept) begin
      for (int b = 0; b < 8; b++)
        if (st_be_i[b]) data_q[young_ptr][8*b +: 8] <= st_data_i[8*b +: 8];
      be_q[young_ptr] <= be_q[young_ptr] | st_be_i;
    end
  end
endmodule
`default_nettype wire
